axi_lite_ram_slave: RTL and testbench



---
 rtl/axi_lite_ram_slave.sv | 131 +++++++++++++
 tb/tb_axi_lite_ram_slave.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_ram_slave.sv
// axi_lite_ram_slave: AXI-lite responder backed by a byte-writable synchronous RAM.
// Ports: clk_i clock, rst_i asynchronous active-high reset;
//   s_aw*/s_w*/s_b* write address, data and response channels;
//   s_ar*/s_r* read address and data channels.
// Define AXI_RAM_ALIGN_CHECK_EN to answer SLVERR to in-range accesses whose low
// address bits are nonzero; otherwise those bits are ignored.
module axi_lite_ram_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    DEPTH_LOG2 = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int ALIGN  = $clog2(STRB_W);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(STRB_W) << DEPTH_LOG2;
`ifdef AXI_RAM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];
    r_state_t              r_state;
    logic                  aw_full, w_full;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;
    logic                  aw_hs, w_hs, b_hs, ar_hs, commit;
    logic                  aw_full_n, w_full_n, bvalid_n;
    logic [ADDR_WIDTH-1:0] aw_off, ar_off;
    logic [1:0]            aw_resp, ar_resp;
    logic [DEPTH_LOG2-1:0] aw_idx, ar_idx;

    always_comb begin
        aw_hs     = s_awvalid && s_awready;
        w_hs      = s_wvalid && s_wready;
        b_hs      = s_bvalid && s_bready;
        ar_hs     = s_arvalid && s_arready;
        // commit fires once per transaction: the cycle both holds are full and no response is pending
        commit    = aw_full && w_full && !s_bvalid;
        aw_full_n = b_hs ? 1'b0 : (aw_full || aw_hs);
        w_full_n  = b_hs ? 1'b0 : (w_full || w_hs);
        bvalid_n  = b_hs ? 1'b0 : (s_bvalid || commit);
        aw_off    = aw_addr - BASE_ADDR;
        ar_off    = s_araddr - BASE_ADDR;
        aw_resp   = (aw_off >= SPAN) ? 2'b11 :
                    (ALIGN_CHK && aw_addr[ALIGN-1:0] != '0) ? 2'b10 : 2'b00;
        ar_resp   = (ar_off >= SPAN) ? 2'b11 :
                    (ALIGN_CHK && s_araddr[ALIGN-1:0] != '0) ? 2'b10 : 2'b00;
        aw_idx    = aw_off[ALIGN+DEPTH_LOG2-1:ALIGN];
        ar_idx    = ar_off[ALIGN+DEPTH_LOG2-1:ALIGN];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            aw_addr   <= '0;
            w_data    <= '0;
            w_strb    <= '0;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bresp   <= 2'b00;
        end else begin
            aw_full   <= aw_full_n;
            w_full    <= w_full_n;
            s_awready <= !aw_full_n && !bvalid_n;
            s_wready  <= !w_full_n && !bvalid_n;
            s_bvalid  <= bvalid_n;
            if (aw_hs) aw_addr <= s_awaddr;
            if (w_hs) begin
                w_data <= s_wdata;
                w_strb <= s_wstrb;
            end
            if (commit) s_bresp <= aw_resp;
        end
    end

    // RAM contents survive reset; only OKAY commits touch it
    always_ff @(posedge clk_i) begin
        if (commit && aw_resp == 2'b00)
            for (int i = 0; i < STRB_W; i++)
                if (w_strb[i]) mem[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
    end

    // reading mem with <= gives old data when a commit lands on the same edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= R_IDLE;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rresp   <= 2'b00;
            s_rdata   <= '0;
        end else if (r_state == R_IDLE) begin
            s_arready <= !ar_hs;
            if (ar_hs) begin
                r_state  <= R_RESP;
                s_rvalid <= 1'b1;
                s_rresp  <= ar_resp;
                s_rdata  <= (ar_resp == 2'b00) ? mem[ar_idx] : '0;
            end
        end else if (s_rready) begin
            r_state   <= R_IDLE;
            s_arready <= 1'b1;
            s_rvalid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// tb_axi_lite_ram_slave: scoreboard bench for axi_lite_ram_slave (default 64-bit, 1024 words).
module tb_axi_lite_ram_slave;
    logic        clk_i = 0, rst_i = 1;
    logic [31:0] s_awaddr = 0, s_araddr = 0;
    logic        s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
    logic [63:0] s_wdata = 0;
    logic [7:0]  s_wstrb = 0;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [63:0] s_rdata;

    typedef struct packed { logic [63:0] data; logic [1:0] resp; } rexp_t;
    logic [1:0]  b_q [$];
    rexp_t       r_q [$];
    logic [63:0] model [int];
    int checks = 0, failures = 0;

    axi_lite_ram_slave dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        if (a >= 32'h2000) return 2'b11;
`ifdef AXI_RAM_ALIGN_CHECK_EN
        if (a[2:0] != 3'b000) return 2'b10;
`endif
        return 2'b00;
    endfunction

    function automatic void expect_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] w;
        b_q.push_back(exp_resp(a));
        if (exp_resp(a) == 2'b00) begin
            w = model.exists(int'(a[12:3])) ? model[int'(a[12:3])] : 64'h0;
            for (int i = 0; i < 8; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
            model[int'(a[12:3])] = w;
        end
    endfunction

    function automatic void expect_read(input logic [31:0] a);
        rexp_t e;
        e.resp = exp_resp(a);
        e.data = (e.resp == 2'b00) ? model[int'(a[12:3])] : 64'h0;
        r_q.push_back(e);
    endfunction

    task automatic aw_send(input logic [31:0] a, input int d, output bit ok);
        int n = 0;
        bit hs = 0;
        repeat (d + 1) @(posedge clk_i);
        #1;
        s_awaddr = a;
        s_awvalid = 1;
        while (!hs && n < 50) begin
            @(negedge clk_i); hs = s_awready;
            @(posedge clk_i); #1; n++;
        end
        s_awvalid = 0;
        ok = hs;
    endtask

    task automatic w_send(input logic [63:0] dat, input logic [7:0] s, input int d, output bit ok);
        int n = 0;
        bit hs = 0;
        repeat (d + 1) @(posedge clk_i);
        #1;
        s_wdata = dat;
        s_wstrb = s;
        s_wvalid = 1;
        while (!hs && n < 50) begin
            @(negedge clk_i); hs = s_wready;
            @(posedge clk_i); #1; n++;
        end
        s_wvalid = 0;
        ok = hs;
    endtask

    task automatic wait_b(output logic [1:0] resp, output bit ok);
        int n = 0;
        ok = 0;
        while (!ok && n < 50) begin
            @(negedge clk_i); ok = s_bvalid; n++;
        end
        resp = s_bresp;
        if (ok) begin
            @(posedge clk_i); #1; s_bready = 1;
            @(posedge clk_i); #1; s_bready = 0;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] dat, input logic [7:0] s,
                            input int awd, input int wd, output logic [1:0] resp, output bit ok);
        bit o1, o2, o3;
        fork
            aw_send(a, awd, o1);
            w_send(dat, s, wd, o2);
        join
        wait_b(resp, o3);
        ok = o1 && o2 && o3;
    endtask

    // lat: rvalid seen right after the AR edge; hold: rdata/rresp/rvalid steady and
    // arready low while rready is held off; ok: whole handshake done and arready back
    task automatic do_read(input logic [31:0] a, input int d, input int stall, output logic [63:0] data,
                           output logic [1:0] resp, output bit lat, output bit hold, output bit ok);
        int n = 0;
        bit hs = 0, rv;
        repeat (d + 1) @(posedge clk_i);
        #1;
        s_araddr = a;
        s_arvalid = 1;
        while (!hs && n < 50) begin
            @(negedge clk_i); hs = s_arready;
            @(posedge clk_i); #1; n++;
        end
        s_arvalid = 0;
        data = 0; resp = 0; lat = 0; hold = 0; ok = 0;
        if (hs) begin
            @(negedge clk_i);
            lat = s_rvalid;
            rv = s_rvalid;
            n = 0;
            while (!rv && n < 50) begin
                @(negedge clk_i); rv = s_rvalid; n++;
            end
            data = s_rdata;
            resp = s_rresp;
            hold = !s_arready;
            repeat (stall) begin
                @(negedge clk_i);
                if (!s_rvalid || s_rdata !== data || s_rresp !== resp || s_arready) hold = 0;
            end
            @(posedge clk_i); #1; s_rready = 1;
            @(posedge clk_i); #1; s_rready = 0;
            @(negedge clk_i);
            ok = rv && !s_rvalid && s_arready;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
        end
        checks++;
        if ({s_bresp, s_rresp, s_rdata} !== 68'h0) begin
            failures++;
            $display("FAIL reset_payload got bresp=%b rresp=%b rdata=%h exp all 0", s_bresp, s_rresp, s_rdata);
        end
        @(posedge clk_i); #1; rst_i = 0;
        @(negedge clk_i);
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b000) begin
            failures++;
            $display("FAIL readys_before_edge got=%b exp=000", {s_awready, s_wready, s_arready});
        end
        @(negedge clk_i);
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            failures++;
            $display("FAIL readys_after_edge got=%b exp=111", {s_awready, s_wready, s_arready});
        end
    endtask

    task automatic test_write_read();
        logic [1:0] br, rr, eb;
        logic [63:0] rd;
        bit ok, lat, hold;
        rexp_t er;
        expect_write(32'h10, 64'h1122334455667788, 8'hFF);
        do_write(32'h10, 64'h1122334455667788, 8'hFF, 0, 1, br, ok);
        eb = b_q.pop_front();
        checks++;
        if (!ok || br !== eb) begin
            failures++;
            $display("FAIL wr10_bresp got=%b ok=%0d exp=%b", br, ok, eb);
        end
        @(negedge clk_i);
        checks++;
        if ({s_awready, s_wready, s_bvalid} !== 3'b110) begin
            failures++;
            $display("FAIL readys_after_b got=%b exp=110", {s_awready, s_wready, s_bvalid});
        end
        expect_read(32'h10);
        do_read(32'h10, 0, 0, rd, rr, lat, hold, ok);
        er = r_q.pop_front();
        checks++;
        if (lat !== 1'b1) begin
            failures++;
            $display("FAIL rd_latency rvalid_after_1=%0d exp=1", lat);
        end
        checks++;
        if (!ok || rd !== er.data || rr !== er.resp) begin
            failures++;
            $display("FAIL rd10 got=%h/%b ok=%0d exp=%h/%b", rd, rr, ok, er.data, er.resp);
        end
    endtask

    task automatic test_strobes();
        logic [1:0] br, rr, eb;
        logic [63:0] rd;
        bit ok, lat, hold;
        rexp_t er;
        expect_write(32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        do_write(32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, 0, br, ok);
        eb = b_q.pop_front();
        checks++;
        if (!ok || br !== eb) begin
            failures++;
            $display("FAIL strb0f_bresp got=%b ok=%0d exp=%b", br, ok, eb);
        end
        expect_write(32'h10, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00);
        do_write(32'h10, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 1, 0, br, ok);
        eb = b_q.pop_front();
        checks++;
        if (!ok || br !== eb) begin
            failures++;
            $display("FAIL strb00_bresp got=%b ok=%0d exp=%b", br, ok, eb);
        end
        expect_read(32'h10);
        do_read(32'h10, 0, 0, rd, rr, lat, hold, ok);
        er = r_q.pop_front();
        checks++;
        if (!ok || rd !== er.data || rr !== er.resp || rd !== 64'h11223344FFFFFFFF) begin
            failures++;
            $display("FAIL strb_merge got=%h/%b exp=%h/%b", rd, rr, er.data, er.resp);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] wa [4] = '{32'h0, 32'h1FF8, 32'h2000, 32'hFFFF_FFF8};
        logic [31:0] ra [4] = '{32'h2000, 32'h0, 32'h1FF8, 32'hFFFF_FFF8};
        logic [1:0] br, rr, eb;
        logic [63:0] rd;
        bit ok, lat, hold;
        rexp_t er;
        for (int i = 0; i < 4; i++) begin
            expect_write(wa[i], 64'hA5A5_0000_0000_0000 | 64'(i), 8'hFF);
            do_write(wa[i], 64'hA5A5_0000_0000_0000 | 64'(i), 8'hFF, 0, 0, br, ok);
            eb = b_q.pop_front();
            checks++;
            if (!ok || br !== eb) begin
                failures++;
                $display("FAIL oor_bresp addr=%h got=%b ok=%0d exp=%b", wa[i], br, ok, eb);
            end
        end
        for (int i = 0; i < 4; i++) begin
            expect_read(ra[i]);
            do_read(ra[i], 0, 0, rd, rr, lat, hold, ok);
            er = r_q.pop_front();
            checks++;
            if (!ok || rd !== er.data || rr !== er.resp) begin
                failures++;
                $display("FAIL oor_read addr=%h got=%h/%b ok=%0d exp=%h/%b", ra[i], rd, rr, ok, er.data, er.resp);
            end
        end
    endtask

    task automatic test_read_stall();
        logic [1:0] br, rr, eb;
        logic [63:0] rd;
        bit okw, okr, lat, hold;
        rexp_t er;
        expect_read(32'h10);
        expect_write(32'h10, 64'h0BAD_F00D_CAFE_0001, 8'hFF);
        fork
            do_read(32'h10, 0, 5, rd, rr, lat, hold, okr);
            do_write(32'h10, 64'h0BAD_F00D_CAFE_0001, 8'hFF, 1, 1, br, okw);
        join
        er = r_q.pop_front();
        eb = b_q.pop_front();
        checks++;
        if (!hold) begin
            failures++;
            $display("FAIL stall_hold stable=%0d exp=1", hold);
        end
        checks++;
        if (!okr || rd !== er.data || rr !== er.resp) begin
            failures++;
            $display("FAIL stall_data got=%h/%b ok=%0d exp=%h/%b", rd, rr, okr, er.data, er.resp);
        end
        checks++;
        if (!okw || br !== eb) begin
            failures++;
            $display("FAIL stall_wr_bresp got=%b ok=%0d exp=%b", br, okw, eb);
        end
    endtask

    task automatic test_read_before_write();
        logic [1:0] br, rr, eb;
        logic [63:0] rd;
        bit okw, okr, lat, hold;
        rexp_t er;
        expect_write(32'h18, 64'h0123_4567_89AB_CDEF, 8'hFF);
        do_write(32'h18, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, br, okw);
        eb = b_q.pop_front();
        checks++;
        if (!okw || br !== eb) begin
            failures++;
            $display("FAIL rbw_setup_bresp got=%b ok=%0d exp=%b", br, okw, eb);
        end
        // AR lands on the same edge as the commit of the second write
        expect_read(32'h18);
        expect_write(32'h18, 64'hFEDC_BA98_7654_3210, 8'hFF);
        fork
            do_write(32'h18, 64'hFEDC_BA98_7654_3210, 8'hFF, 0, 0, br, okw);
            do_read(32'h18, 1, 0, rd, rr, lat, hold, okr);
        join
        er = r_q.pop_front();
        eb = b_q.pop_front();
        checks++;
        if (!okr || rd !== er.data || rr !== er.resp) begin
            failures++;
            $display("FAIL rbw_old_data got=%h/%b ok=%0d exp=%h/%b", rd, rr, okr, er.data, er.resp);
        end
        checks++;
        if (!okw || br !== eb) begin
            failures++;
            $display("FAIL rbw_bresp got=%b ok=%0d exp=%b", br, okw, eb);
        end
        expect_read(32'h18);
        do_read(32'h18, 0, 0, rd, rr, lat, hold, okr);
        er = r_q.pop_front();
        checks++;
        if (!okr || rd !== er.data || rr !== er.resp) begin
            failures++;
            $display("FAIL rbw_new_data got=%h/%b ok=%0d exp=%h/%b", rd, rr, okr, er.data, er.resp);
        end
    endtask

    task automatic test_unaligned();
        logic [1:0] br, rr, eb;
        logic [63:0] rd;
        bit ok, lat, hold;
        rexp_t er;
        expect_read(32'h14);
        do_read(32'h14, 0, 0, rd, rr, lat, hold, ok);
        er = r_q.pop_front();
        checks++;
        if (!ok || rd !== er.data || rr !== er.resp) begin
            failures++;
            $display("FAIL unal_read14 got=%h/%b ok=%0d exp=%h/%b", rd, rr, ok, er.data, er.resp);
        end
        expect_write(32'h13, 64'h0102_0304_0506_0708, 8'hFF);
        do_write(32'h13, 64'h0102_0304_0506_0708, 8'hFF, 0, 0, br, ok);
        eb = b_q.pop_front();
        checks++;
        if (!ok || br !== eb) begin
            failures++;
            $display("FAIL unal_wr13_bresp got=%b ok=%0d exp=%b", br, ok, eb);
        end
        expect_read(32'h10);
        do_read(32'h10, 0, 0, rd, rr, lat, hold, ok);
        er = r_q.pop_front();
        checks++;
        if (!ok || rd !== er.data || rr !== er.resp) begin
            failures++;
            $display("FAIL unal_after_wr got=%h/%b ok=%0d exp=%h/%b", rd, rr, ok, er.data, er.resp);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] br, rr, eb;
        logic [63:0] rd;
        bit ok, ok2, lat, hold, hs, quiet;
        rexp_t er;
        @(posedge clk_i); #1;
        s_awaddr = 32'h20;
        s_awvalid = 1;
        @(negedge clk_i); hs = s_awready;
        @(posedge clk_i); #1; s_awvalid = 0;
        @(negedge clk_i);
        checks++;
        if (!hs || {s_awready, s_wready} !== 2'b01) begin
            failures++;
            $display("FAIL aw_hold hs=%0d got=%b exp=01", hs, {s_awready, s_wready});
        end
        rst_i = 1;
        #1;
        checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b0) begin
            failures++;
            $display("FAIL async_reset got=%b exp=00000", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
        end
        @(posedge clk_i); #1; rst_i = 0;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid} !== 4'b1110) begin
            failures++;
            $display("FAIL post_reset got=%b exp=1110", {s_awready, s_wready, s_arready, s_bvalid});
        end
        // a stale AW hold would let this lone W commit
        w_send(64'hCAFE_BABE_1234_5678, 8'hFF, 0, ok);
        quiet = 1;
        repeat (4) begin
            @(negedge clk_i);
            if (s_bvalid) quiet = 0;
        end
        checks++;
        if (!ok || !quiet) begin
            failures++;
            $display("FAIL w_only_no_b ok=%0d bvalid_seen=%0d exp=0", ok, !quiet);
        end
        expect_write(32'h28, 64'hCAFE_BABE_1234_5678, 8'hFF);
        aw_send(32'h28, 0, ok);
        wait_b(br, ok2);
        eb = b_q.pop_front();
        checks++;
        if (!ok || !ok2 || br !== eb) begin
            failures++;
            $display("FAIL post_reset_wr got=%b ok=%0d/%0d exp=%b", br, ok, ok2, eb);
        end
        for (int i = 0; i < 2; i++) begin
            expect_read(i == 0 ? 32'h28 : 32'h10);
            do_read(i == 0 ? 32'h28 : 32'h10, 0, 0, rd, rr, lat, hold, ok);
            er = r_q.pop_front();
            checks++;
            if (!ok || rd !== er.data || rr !== er.resp) begin
                failures++;
                $display("FAIL post_reset_rd%0d got=%h/%b ok=%0d exp=%h/%b", i, rd, rr, ok, er.data, er.resp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [6];
        logic [63:0] dat, rd;
        logic [1:0] br, rr, eb;
        bit ok, lat, hold;
        rexp_t er;
        for (int i = 0; i < 6; i++) begin
            addrs[i] = {19'b0, 10'($urandom_range(4, 1023)), 3'b0};
            dat = {$urandom, $urandom};
            expect_write(addrs[i], dat, 8'hFF);
            do_write(addrs[i], dat, 8'hFF, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), br, ok);
            eb = b_q.pop_front();
            checks++;
            if (!ok || br !== eb) begin
                failures++;
                $display("FAIL b2b_wr%0d addr=%h got=%b ok=%0d exp=%b", i, addrs[i], br, ok, eb);
            end
        end
        for (int i = 0; i < 6; i++) begin
            expect_read(addrs[i]);
            do_read(addrs[i], 0, 0, rd, rr, lat, hold, ok);
            er = r_q.pop_front();
            checks++;
            if (!ok || !lat || rd !== er.data || rr !== er.resp) begin
                failures++;
                $display("FAIL b2b_rd%0d addr=%h got=%h/%b ok=%0d lat=%0d exp=%h/%b",
                         i, addrs[i], rd, rr, ok, lat, er.data, er.resp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobes();
        test_out_of_range();
        test_read_stall();
        test_read_before_write();
        test_unaligned();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
